// File: rtl/jk_cell_driver.sv
// Initiator for a gate-level JK cell: sequences j/k, the clk strobe and the
// active-low clear strobe, then reads q back and retries or flags an error.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for req; command and expected q latched on accept
// SETUP   | j/k held stable before the strobe
// PULSE   | clk_out high (rL_out low for clear)
// RELEASE | strobes return inactive, j/k unchanged
// CHECK   | q_in compared with the expected value
module jk_cell_driver #(
    parameter int SETUP_CYCLES = 2,
    parameter int PULSE_CYCLES = 2,
    parameter int MAX_RETRY    = 1
) (
    input  logic       MasterClock,
    input  logic       reset,
    input  logic       req,
    input  logic [1:0] cmd,
    input  logic       target,
    input  logic       q_in,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic       err_flag,
    output logic       j,
    output logic       k,
    output logic       clk_out,
    output logic       rL_out
);

    localparam int MAX_PHASE = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
    localparam int CW = (MAX_PHASE > 1) ? $clog2(MAX_PHASE) : 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [CW-1:0] SETUP_LOAD = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRY);

    typedef enum logic [2:0] {IDLE, SETUP, PULSE, RELEASE, CHECK} state_t;
    typedef enum logic [1:0] {
        CMD_HOLD   = 2'b00,
        CMD_WRITE  = 2'b01,
        CMD_TOGGLE = 2'b10,
        CMD_CLEAR  = 2'b11
    } cmd_t;

    state_t        state_q, state_d;
    cmd_t          cmd_q, cmd_d;
    logic          exp_q, exp_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] retry_q, retry_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
    logic          err_flag_q, err_flag_d;
    logic          j_q, j_d;
    logic          k_q, k_d;
    logic          clk_out_q, clk_out_d;
    logic          rL_out_q, rL_out_d;

    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        exp_d      = exp_q;
        cnt_d      = cnt_q;
        retry_d    = retry_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        error_d    = 1'b0;
        err_flag_d = err_flag_q;
        j_d        = j_q;
        k_d        = k_q;
        clk_out_d  = clk_out_q;
        rL_out_d   = rL_out_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    cmd_d      = cmd_t'(cmd);
                    err_flag_d = 1'b0;
                    retry_d    = '0;
                    busy_d     = 1'b1;
                    cnt_d      = SETUP_LOAD;
                    state_d    = SETUP;
                    case (cmd_t'(cmd))
                        CMD_WRITE: begin
                            exp_d = target;
                            j_d   = target;
                            k_d   = ~target;
                        end
                        CMD_TOGGLE: begin
                            exp_d = ~q_in;
                            j_d   = 1'b1;
                            k_d   = 1'b1;
                        end
                        CMD_HOLD: begin
                            exp_d = q_in;
                            j_d   = 1'b0;
                            k_d   = 1'b0;
                        end
                        CMD_CLEAR: begin
                            exp_d = 1'b0;
                            j_d   = 1'b0;
                            k_d   = 1'b0;
                        end
                    endcase
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
                    state_d = PULSE;
                    cnt_d   = PULSE_LOAD;
                    if (cmd_q == CMD_CLEAR) rL_out_d = 1'b0;
                    else                    clk_out_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            PULSE: begin
                if (cnt_q == '0) begin
                    state_d   = RELEASE;
                    clk_out_d = 1'b0;
                    rL_out_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RELEASE: state_d = CHECK;
            CHECK: begin
                if (q_in == exp_q) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    j_d     = 1'b0;
                    k_d     = 1'b0;
                    state_d = IDLE;
                end else if (retry_q < RETRY_MAX) begin
                    // retries always drive straight toward exp so a late toggle cannot undo itself
                    retry_d = retry_q + 1'b1;
                    cmd_d   = CMD_WRITE;
                    j_d     = exp_q;
                    k_d     = ~exp_q;
                    cnt_d   = SETUP_LOAD;
                    state_d = SETUP;
                end else begin
                    error_d    = 1'b1;
                    err_flag_d = 1'b1;
                    busy_d     = 1'b0;
                    j_d        = 1'b0;
                    k_d        = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge MasterClock) begin
        if (reset) begin
            state_q    <= IDLE;
            cmd_q      <= CMD_HOLD;
            exp_q      <= 1'b0;
            cnt_q      <= '0;
            retry_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_flag_q <= 1'b0;
            j_q        <= 1'b0;
            k_q        <= 1'b0;
            clk_out_q  <= 1'b0;
            rL_out_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            exp_q      <= exp_d;
            cnt_q      <= cnt_d;
            retry_q    <= retry_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            err_flag_q <= err_flag_d;
            j_q        <= j_d;
            k_q        <= k_d;
            clk_out_q  <= clk_out_d;
            rL_out_q   <= rL_out_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = error_q;
    assign err_flag = err_flag_q;
    assign j        = j_q;
    assign k        = k_q;
    assign clk_out  = clk_out_q;
    assign rL_out   = rL_out_q;

endmodule

// File: tb/tb_jk_cell_driver.sv
// Bench for jk_cell_driver: behavioural JK cell with fault modes, directed
// scenarios then random commands checked cycle by cycle against a timeline model.
module tb_jk_cell_driver;

    localparam int S = 2;
    localparam int P = 2;
    localparam int R = 1;
    localparam int ATT = S + P + 2;

    logic       MasterClock = 1'b0;
    logic       reset, req, target;
    logic [1:0] cmd;
    logic       busy, done, error, err_flag, j, k, clk_out, rL_out;
    logic       q_in;

    int   n_checks = 0;
    int   n_err    = 0;
    logic pq       = 1'b0;
    logic err_last = 1'b0;

    logic cell_q      = 1'b0;
    bit   stuck0      = 1'b0;
    int   cmd_seq     = 0;
    int   ign_seq     = -1;
    int   ignored_seq = -1;

    wire [7:0] obs_v = {busy, done, error, err_flag, j, k, clk_out, rL_out};

    jk_cell_driver #(
        .SETUP_CYCLES(S),
        .PULSE_CYCLES(P),
        .MAX_RETRY   (R)
    ) dut (
        .MasterClock(MasterClock),
        .reset      (reset),
        .req        (req),
        .cmd        (cmd),
        .target     (target),
        .q_in       (q_in),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .err_flag   (err_flag),
        .j          (j),
        .k          (k),
        .clk_out    (clk_out),
        .rL_out     (rL_out)
    );

    always #5 MasterClock = ~MasterClock;

    // cell: clear is asynchronous and dominant; optional stuck-at-0 or one ignored capture
    always @(posedge clk_out or negedge rL_out) begin
        if (!rL_out) begin
            cell_q <= 1'b0;
        end else if (stuck0) begin
            cell_q <= 1'b0;
        end else if (ign_seq == cmd_seq && ignored_seq != cmd_seq) begin
            ignored_seq <= cmd_seq;
        end else begin
            case ({j, k})
                2'b10:   cell_q <= 1'b1;
                2'b01:   cell_q <= 1'b0;
                2'b11:   cell_q <= ~cell_q;
                default: cell_q <= cell_q;
            endcase
        end
    end
    assign q_in = cell_q;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b ({busy,done,error,err_flag,j,k,clk,rL})",
                   tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] busy_vec(input int c_cmd, input logic e, input int off);
        logic jj, kk, pulse;
        jj = 1'b0;
        kk = 1'b0;
        if (c_cmd == 1) begin
            jj = e;
            kk = ~e;
        end else if (c_cmd == 2) begin
            jj = 1'b1;
            kk = 1'b1;
        end
        pulse = (off >= S) && (off < S + P);
        return {1'b1, 1'b0, 1'b0, 1'b0, jj, kk, pulse && (c_cmd != 3), !(pulse && (c_cmd == 3))};
    endfunction

    // called at a negedge; issues the command and checks every cycle until done/error
    task automatic run_cmd(input int c_cmd, input logic tgt, input int fault);
        logic       e, q;
        bit         ok;
        int         n_att, total, ea;
        logic [7:0] expv;
        cmd_seq++;
        stuck0  = (fault == 1);
        ign_seq = (fault == 2) ? cmd_seq : -1;
        req     = 1'b1;
        cmd     = c_cmd[1:0];
        target  = tgt;
        case (c_cmd)
            1:       e = tgt;
            2:       e = ~pq;
            0:       e = pq;
            default: e = 1'b0;
        endcase
        q = pq;
        ok = 1'b0;
        n_att = 0;
        for (int a = 0; a <= R && !ok; a++) begin
            ea = (a == 0) ? c_cmd : 1;
            if (ea == 3)                 q = 1'b0;
            else if (fault == 1)         q = 1'b0;
            else if (fault == 2 && a == 0) q = q;
            else if (ea == 1)            q = e;
            else if (ea == 2)            q = ~q;
            n_att++;
            ok = (q === e);
        end
        pq = q;
        total = (S + P + 3) + (n_att - 1) * ATT;
        for (int c = 1; c <= total; c++) begin
            @(negedge MasterClock);
            if (c < total)
                expv = busy_vec(((c - 1) / ATT == 0) ? c_cmd : 1, e, (c - 1) % ATT);
            else
                expv = {1'b0, ok, !ok, !ok, 4'b0001};
            chk($sformatf("cmd%0d_op%0d_c%0d", cmd_seq, c_cmd, c), obs_v, expv);
            if (c < total) begin
                req    = 1'($urandom_range(0, 1));
                cmd    = 2'($urandom);
                target = 1'($urandom);
            end else begin
                req = 1'b0;
            end
        end
        err_last = !ok;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge MasterClock);
            chk("idle", obs_v, {3'b000, err_last, 4'b0001});
        end
    endtask

    initial begin
        reset  = 1'b1;
        req    = 1'b0;
        cmd    = 2'b00;
        target = 1'b0;
        repeat (3) @(negedge MasterClock);
        chk("reset_state", obs_v, 8'b0000_0001);
        reset = 1'b0;
        idle(1);

        run_cmd(1, 1'b1, 0);      // write 1
        run_cmd(2, 1'b0, 0);      // toggle from 1, back-to-back
        idle(2);
        run_cmd(1, 1'b1, 0);
        run_cmd(3, 1'b0, 0);      // clear from 1
        idle(1);
        run_cmd(1, 1'b1, 1);      // stuck at 0: retry then error
        idle(3);
        run_cmd(1, 1'b1, 0);
        run_cmd(2, 1'b0, 2);      // first capture ignored: retry writes toward 0

        // reset in the first PULSE cycle of a write
        cmd_seq++;
        stuck0  = 1'b0;
        ign_seq = -1;
        req     = 1'b1;
        cmd     = 2'b01;
        target  = 1'b0;
        for (int c = 1; c <= S + 1; c++) begin
            @(negedge MasterClock);
            chk($sformatf("rst_seq_c%0d", c), obs_v, busy_vec(1, 1'b0, c - 1));
            req = 1'b0;
        end
        reset = 1'b1;
        @(negedge MasterClock);
        reset = 1'b0;
        chk("rst_mid_op", obs_v, 8'b0000_0001);
        pq       = 1'b0;
        err_last = 1'b0;
        run_cmd(2, 1'b0, 0);      // accepted right after reset

        for (int i = 0; i < 40; i++) begin
            int f;
            f = $urandom_range(0, 9);
            run_cmd($urandom_range(0, 3), 1'($urandom), (f == 0) ? 1 : (f == 1) ? 2 : 0);
            idle($urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/jk_cell_driver.md
Name: jk_cell_driver

Overview:
- Initiator side of the JK flip-flop cell interface: accepts a one-cycle command (write, toggle, hold, clear) and sequences j/k/clk/rL on a gate-level JK cell.
- Reads back the cell's q output and confirms that the cell reached the expected state.
- Used in the emulation harness to exercise and self-check JK cells in the Flare gate-level netlist.
- Runs entirely on MasterClock; the cell's clk and rL are generated as registered strobes.

Parameters:
- SETUP_CYCLES, 2, cycles j/k are held stable before clk rises (minimum 1).
- PULSE_CYCLES, 2, cycles clk_out (or rL_out, for clear) is held active (minimum 1).
- MAX_RETRY, 1, extra attempts after a readback mismatch before error (0 means no retry).

Ports:
- MasterClock  input  1  sole clock; all logic updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  1  command strobe; sampled only when busy=0.
- cmd  input  2  command code: 00 hold, 01 write, 10 toggle, 11 clear.
- target  input  1  value to write; used only when cmd=01.
- busy  output  1  high from the cycle after acceptance until done or error.
- done  output  1  one-cycle pulse on successful readback.
- error  output  1  one-cycle pulse when retries are exhausted.
- err_flag  output  1  sticky error; cleared by reset or by the next accepted req.
- j  output  1  J drive to the cell.
- k  output  1  K drive to the cell.
- clk_out  output  1  clock strobe to the cell (active high; the rising edge is the cell's capture edge).
- rL_out  output  1  active-low clear strobe to the cell.
- q_in  input  1  the cell's q, treated as settled within one MasterClock.

Behaviour:
- Reset values: j=0, k=0, clk_out=0, rL_out=1, busy=0, done=0, error=0, err_flag=0; state IDLE; retry count 0.
- Reset mid-operation aborts the sequence. All outputs take their reset values at that edge, and no done or error is produced.
- States: IDLE, SETUP, PULSE, RELEASE, CHECK.
- IDLE:
  - req=1 is accepted. The block latches cmd and sets exp:
    - write: exp = target
    - toggle: exp = ~q_in
    - hold: exp = q_in
    - clear: exp = 0
  - On acceptance: clear err_flag, set retry count to 0, go to SETUP, set busy=1.
- SETUP: lasts SETUP_CYCLES. j/k are driven throughout:
  - write: j = exp, k = ~exp
  - toggle: j = 1, k = 1
  - hold: j = 0, k = 0
  - clear: j = 0, k = 0
- PULSE: lasts PULSE_CYCLES. j/k stay unchanged.
  - clear: rL_out=0; clk_out stays 0.
  - all other commands: clk_out=1.
- RELEASE: one cycle. clk_out=0, rL_out=1, j/k unchanged.
- CHECK: one cycle. q_in is sampled and compared with exp.
  - Match: done=1 in the next cycle, busy=0, j=k=0, return to IDLE.
  - Mismatch, retry count < MAX_RETRY: increment the count and return to SETUP. The retry always uses write excitation toward exp (j = exp, k = ~exp), never toggle. This stops a re-toggle from cancelling a partial success.
  - Mismatch, retries exhausted: error=1 and err_flag=1 in the next cycle, busy=0, return to IDLE.
- Latency: with req sampled at edge N, done (or error, with no retry) is high in cycle N+SETUP_CYCLES+PULSE_CYCLES+3. Each retry adds SETUP_CYCLES+PULSE_CYCLES+2 cycles.
- Back-to-back commands: req in the same cycle that done is high is accepted, since busy is already 0.
- req while busy=1 is ignored, with no queuing.
- Unused target is don't-care for hold, toggle and clear.
- clk_out and rL_out are never active in the same cycle.
- The retry counter is $clog2(MAX_RETRY+1) bits wide (minimum 1) and saturates at MAX_RETRY.

Test Plan:
- Reset, then write target=1 with q_in following the cell model: j=1, k=0 through SETUP, clk_out high 2 cycles; done pulses at N+7, busy low at the same cycle.
- Toggle with cell q=1: j=k=1, exp=0; model q falls after clk_out rises; done at N+7, err_flag=0.
- Clear with model q=1: rL_out low for 2 cycles, clk_out stays 0 throughout; q reads 0 and done asserts.
- Model forced stuck at 0 on write target=1, MAX_RETRY=1: one retry; error pulses at N+13 and err_flag stays 1 until the next req.
- Toggle model that ignores the first clk then works, MAX_RETRY=1: retry drives j=0, k=1 toward exp=0; done at N+13, no error.
- reset asserted during PULSE: next cycle clk_out=0, busy=0, rL_out=1; no done or error; req=1 in the following cycle is accepted, with busy high the cycle after.
